// File: rtl/delay_line_prog.sv
// Programmable-tap delay line with stall, flush and a fill-status flag.
// Define DELAY_LINE_OUTREG_EN to register the tap-mux outputs.
module delay_line_prog #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SEL_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] input_data,
    input  logic [SEL_W-1:0] delay_sel,
    output logic [WIDTH-1:0] output_data,
    output logic             out_valid,
    output logic             primed
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [CNT_W-1:0] fill_q, fill_d;

    logic [SEL_W-1:0] sel_c;
    logic [IDX_W-1:0] tap_idx;
    logic [WIDTH-1:0] tap_data;
    logic             tap_valid;
    logic             tap_primed;

    always_comb begin
        stage_d = stage_q;
        vld_d   = vld_q;
        fill_d  = fill_q;
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_d[k] = '0;
            end
            vld_d  = '0;
            fill_d = '0;
        end else if (en) begin
            stage_d[0] = input_data;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            vld_d = {vld_q[DEPTH-2:0], in_valid};
            if (fill_q != FULL_CNT) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            vld_q  <= '0;
            fill_q <= '0;
        end else begin
            stage_q <= stage_d;
            vld_q   <= vld_d;
            fill_q  <= fill_d;
        end
    end

    // Selects past the last stage clamp to it, so the index is always in range.
    assign sel_c      = (delay_sel > LAST_SEL) ? LAST_SEL : delay_sel;
    assign tap_idx    = IDX_W'(sel_c);
    assign tap_data   = stage_q[tap_idx];
    assign tap_valid  = vld_q[tap_idx];
    assign tap_primed = 32'(fill_q) > 32'(sel_c);

`ifdef DELAY_LINE_OUTREG_EN
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             primed_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            primed_q    <= 1'b0;
        end else if (flush) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            primed_q    <= 1'b0;
        end else if (en) begin
            out_data_q  <= tap_data;
            out_valid_q <= tap_valid;
            primed_q    <= tap_primed;
        end
    end

    assign output_data = out_data_q;
    assign out_valid   = out_valid_q;
    assign primed      = primed_q;
`else
    assign output_data = tap_data;
    assign out_valid   = tap_valid;
    assign primed      = tap_primed;
`endif

endmodule

// File: tb/tb_delay_line_prog.sv
// Bench for delay_line_prog: directed steps then random traffic,
// checked against a history-queue model of the delay line.
module tb_delay_line_prog;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SEL_W = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic             en;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] input_data;
    logic [SEL_W-1:0] delay_sel;
    logic [WIDTH-1:0] output_data;
    logic             out_valid;
    logic             primed;

    int checks = 0;
    int errors = 0;

    delay_line_prog #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .SEL_W(SEL_W)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .en(en),
        .flush(flush),
        .in_valid(in_valid),
        .input_data(input_data),
        .delay_sel(delay_sel),
        .output_data(output_data),
        .out_valid(out_valid),
        .primed(primed)
    );

    always #5 CLK = ~CLK;

    // Model: newest word at the front; words never shifted in read as zero.
    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             v;
    } w_t;

    w_t hist[$];
    int shifts = 0;
    logic [WIDTH-1:0] r_d = '0;
    logic             r_v = 1'b0;
    logic             r_p = 1'b0;

    function automatic int clamp_sel();
        int s;
        s = int'(delay_sel);
        return (s > DEPTH - 1) ? DEPTH - 1 : s;
    endfunction

    task automatic tap(output logic [WIDTH-1:0] d, output logic v, output logic p);
        int s;
        s = clamp_sel();
        d = '0;
        v = 1'b0;
        if (s < hist.size()) begin
            d = hist[s].d;
            v = hist[s].v;
        end
        p = (shifts > s);
    endtask

    task automatic model_reset();
        hist.delete();
        shifts = 0;
        r_d = '0;
        r_v = 1'b0;
        r_p = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic f,
                              input logic v, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] td;
        logic tv, tp;
        w_t w;
        tap(td, tv, tp);
        if (f) begin
            model_reset();
        end else if (e) begin
            r_d = td;
            r_v = tv;
            r_p = tp;
            w.d = d;
            w.v = v;
            hist.push_front(w);
            if (hist.size() > DEPTH) begin
                void'(hist.pop_back());
            end
            shifts++;
        end
    endtask

    task automatic chk(input string tag);
        logic [WIDTH-1:0] ed;
        logic ev, ep;
`ifdef DELAY_LINE_OUTREG_EN
        ed = r_d;
        ev = r_v;
        ep = r_p;
`else
        tap(ed, ev, ep);
`endif
        checks++;
        assert ({output_data, out_valid, primed} === {ed, ev, ep})
        else begin
            errors++;
            $error("FAIL %s: data/valid/primed got %h/%b/%b expected %h/%b/%b",
                   tag, output_data, out_valid, primed, ed, ev, ep);
        end
    endtask

    task automatic step(input string tag, input logic e, input logic f,
                        input logic v, input logic [WIDTH-1:0] d);
        en = e;
        flush = f;
        in_valid = v;
        input_data = d;
        @(posedge CLK);
        model_edge(e, f, v, d);
        #1;
        chk(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] pat;
        RST = 1'b0;
        en = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        input_data = '0;
        delay_sel = '0;
        #2;
        chk("reset_state");
        #5;
        RST = 1'b1;

        // Latency sweep across every tap
        for (int s = 0; s < DEPTH; s++) begin
            delay_sel = SEL_W'(s);
            step("lat_flush", 1'b0, 1'b1, 1'b0, 8'h00);
            for (int i = 1; i <= 5; i++) begin
                pat = WIDTH'(8'h11 * i);
                step("latency", 1'b1, 1'b0, 1'b1, pat);
            end
        end

        // Out-of-range select clamps; switching tap is immediate
        delay_sel = 4'd7;
        step("clamp_flush", 1'b0, 1'b1, 1'b0, 8'h00);
        step("clamp", 1'b1, 1'b0, 1'b1, 8'h11);
        step("clamp", 1'b1, 1'b0, 1'b1, 8'h22);
        step("clamp", 1'b1, 1'b0, 1'b1, 8'h33);
        step("clamp", 1'b1, 1'b0, 1'b1, 8'h44);
        delay_sel = 4'd1;
        #1;
        chk("sel_switch");
`ifndef DELAY_LINE_OUTREG_EN
        checks++;
        assert (output_data === 8'h33)
        else begin
            errors++;
            $error("FAIL sel_switch_const: got %h expected 33", output_data);
        end
`endif

        // Stall holds the line and the fill count
        step("stall_flush", 1'b0, 1'b1, 1'b0, 8'h00);
        step("stall_load", 1'b1, 1'b0, 1'b1, 8'hA5);
        step("stall_load", 1'b1, 1'b0, 1'b1, 8'h5B);
        for (int i = 0; i < 3; i++) begin
            step("stall_hold", 1'b0, 1'b0, 1'b1, 8'hC3);
        end
        delay_sel = 4'd2;
        #1;
        chk("stall_primed");
        step("stall_resume", 1'b1, 1'b0, 1'b0, 8'h00);

        // Flush beats enable and drops the input word
        delay_sel = 4'd0;
        step("flush_pri", 1'b1, 1'b1, 1'b1, 8'hFF);
        for (int s = 1; s < DEPTH; s++) begin
            delay_sel = SEL_W'(s);
            #1;
            chk("flush_taps");
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            step("post_flush", 1'b1, 1'b0, 1'b0, 8'h00);
        end

        // Valid flags travel with their words
        delay_sel = 4'd2;
        step("vld_flush", 1'b0, 1'b1, 1'b0, 8'h00);
        step("vld", 1'b1, 1'b0, 1'b1, 8'h01);
        step("vld", 1'b1, 1'b0, 1'b0, 8'h02);
        step("vld", 1'b1, 1'b0, 1'b1, 8'h03);
        for (int i = 0; i < 4; i++) begin
            step("vld_drain", 1'b1, 1'b0, 1'b0, 8'h00);
        end

        // Asynchronous reset mid-stream, no clock edge needed
        step("pre_rst", 1'b1, 1'b0, 1'b1, 8'h77);
        step("pre_rst", 1'b1, 1'b0, 1'b1, 8'h88);
        RST = 1'b0;
        model_reset();
        #1;
        chk("async_reset");
        @(negedge CLK);
        RST = 1'b1;
        step("post_rst", 1'b1, 1'b0, 1'b1, 8'h99);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            delay_sel = SEL_W'($urandom_range(0, 15));
            step("random", 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 19) == 0),
                 1'($urandom), WIDTH'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                delay_sel = SEL_W'($urandom_range(0, 15));
                #1;
                chk("random_sel");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_line_prog.md
# delay_line_prog

Parametrised, programmable-tap shift delay line: WIDTH-bit data with a per-word valid flag passes through DEPTH register stages, and the output is taken from a run-time-selected tap. It adds shift-enable (stall), synchronous flush and a fill-status flag to the fixed four-stage, 8-bit DFF chain. It sits in datapaths that must be aligned with a variable-latency side path, e.g. matching a control stream to a pipelined arithmetic unit.

## Interface
- WIDTH, 8, data word width (≥1)
- DEPTH, 4, number of register stages (2..16)
- SEL_W, 4, width of delay_sel; 2^SEL_W ≥ DEPTH
- CLK  input  1  clock, rising edge active
- RST  input  1  reset; one clock, reset asynchronous and active-low
- en  input  1  shift enable; 0 = all stages hold
- flush  input  1  synchronous clear of all stages and fill count
- in_valid  input  1  valid flag accompanying input_data
- input_data  input  WIDTH  data in
- delay_sel  input  SEL_W  tap select; latency = sel_c + 1 enabled shifts
- output_data  output  WIDTH  word at selected tap
- out_valid  output  1  valid flag at selected tap
- primed  output  1  selected tap holds a word shifted in since last reset/flush

## Operation
- Storage: stage[0..DEPTH-1] of WIDTH bits, vld[0..DEPTH-1], fill_cnt (0..DEPTH, saturating).
- sel_c = min(delay_sel, DEPTH-1); out-of-range selects clamp to last stage.
- Rising edge, priority order: flush=1 → all stage, vld cleared to 0, fill_cnt←0 (en ignored). Else en=1 → stage[0]←input_data, vld[0]←in_valid, stage[k]←stage[k-1], vld[k]←vld[k-1]; fill_cnt←min(fill_cnt+1, DEPTH). Else hold everything.
- output_data = stage[sel_c]; out_valid = vld[sel_c]; primed = (fill_cnt > sel_c). All combinational from registers plus delay_sel.
- delay_sel change mid-stream: output switches to new tap in same cycle; no data lost, stages unaffected; primed re-evaluated immediately.
- Word with in_valid=0 still shifts; only its vld bit is 0.

## Timing
- Reset (RST low, async): all stages, vld, fill_cnt = 0 immediately; output_data=0, out_valid=0, primed=0. Held while RST low; first shift at first rising edge after release.
- Latency: word sampled at enabled edge n appears on output_data after edge n+sel_c, i.e. sel_c+1 enabled edges including the capture edge; disabled edges do not count.
- Throughput: one word per enabled cycle, no bubbles.
- Flush and en both high: flush wins; input word discarded.
- Flush with RST high mid-stream: outputs 0 after that edge; primed=0 until sel_c+1 further enabled shifts.
- fill_cnt saturates at DEPTH; never wraps.

## Configuration
- DELAY_LINE_OUTREG_EN defined: extra output register after tap mux (output_data, out_valid, primed registered). Loads every edge when en=1 or flush=1 (flush loads 0), holds when en=0. Latency becomes sel_c+2 enabled edges; delay_sel change visible after next enabled edge. Reset value 0.
- Undefined: outputs combinational from tap mux as above.

## Test plan
- Reset: drive RST=0 mid-stream with stages loaded → output_data=0x00, out_valid=0, primed=0 immediately, no clock needed.
- Latency sweep (WIDTH=8, DEPTH=4, en=1): input 0x11,0x22,0x33,... valid=1; delay_sel=0..3 → 0x11 on output after 1,2,3,4 edges respectively; primed rises on same edge.
- Clamp/select switch: delay_sel=7 → behaves as 3; switching sel 3→1 with stages 0x44,0x33,0x22,0x11 → output jumps 0x11→0x33 same cycle.
- Stall: en=0 for 3 cycles after loading 0xA5 at stage 1 → output held 0xA5, fill_cnt unchanged; resume → 0xA5 advances to stage 2 on next edge.
- Flush priority: flush=1, en=1, input 0xFF → all stages 0, out_valid=0, primed=0; 0xFF never appears.
- Valid tracking: pattern in_valid 1,0,1 with data 0x01,0x02,0x03, sel=2 → out_valid 1,0,1 aligned with 0x01,0x02,0x03.
